// File: rtl/id_ex_hazard_buffer.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion on
// stall or flush, and saturating stall/flush event counters.

package core_pkg;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    NO_WRITEBACK        = 2'd0,
    ALU_RESULT_WRITEBACK = 2'd1,
    MEMORY_WRITEBACK    = 2'd2,
    PC_PLUS_4_WRITEBACK = 2'd3
  } write_back_mux_selector;
endpackage

module id_ex_hazard_buffer
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid_ip,
  input  logic [6:0]             id_opcode_ip,
  input  logic [4:0]             id_rs1_ip,
  input  logic [4:0]             id_rs2_ip,
  input  logic [4:0]             id_rd_ip,
  input  write_back_mux_selector id_wb_mux_ip,
  input  logic [XLEN-1:0]        id_rs1_data_ip,
  input  logic [XLEN-1:0]        id_rs2_data_ip,
  input  logic [XLEN-1:0]        id_imm_ip,
  input  logic [XLEN-1:0]        id_pc_ip,
  input  logic                   flush_ip,
  output logic                   ex_valid_op,
  output logic [6:0]             ex_opcode_op,
  output logic [4:0]             ex_rs1_op,
  output logic [4:0]             ex_rs2_op,
  output logic [4:0]             ex_rd_op,
  output write_back_mux_selector ex_wb_mux_op,
  output logic [XLEN-1:0]        ex_rs1_data_op,
  output logic [XLEN-1:0]        ex_rs2_data_op,
  output logic [XLEN-1:0]        ex_imm_op,
  output logic [XLEN-1:0]        ex_pc_op,
  output logic                   stall_op,
  output logic [CNT_W-1:0]       stall_count_op,
  output logic [CNT_W-1:0]       flush_count_op
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic uses_rs1;
  logic uses_rs2;
  logic load_use;
  logic take_id;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode_ip)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Decoded from registered EX state only, so there is no combinational path
  // from EX back into itself; a bubble in EX always clears the hazard.
  assign load_use = ex_valid_op && (ex_opcode_op == OPCODE_LOAD) && (ex_rd_op != 5'd0) &&
                    id_valid_ip &&
                    ((uses_rs1 && (id_rs1_ip == ex_rd_op)) ||
                     (uses_rs2 && (id_rs2_ip == ex_rd_op)));

  assign stall_op = load_use && !flush_ip;

  assign take_id = !reset && !flush_ip && !stall_op && id_valid_ip;

  always_ff @(posedge clk) begin
    if (take_id) begin
      ex_valid_op    <= 1'b1;
      ex_opcode_op   <= id_opcode_ip;
      ex_rs1_op      <= id_rs1_ip;
      ex_rs2_op      <= id_rs2_ip;
      ex_rd_op       <= id_rd_ip;
      ex_wb_mux_op   <= id_wb_mux_ip;
      ex_rs1_data_op <= id_rs1_data_ip;
      ex_rs2_data_op <= id_rs2_data_ip;
      ex_imm_op      <= id_imm_ip;
      ex_pc_op       <= id_pc_ip;
    end else begin
      ex_valid_op    <= 1'b0;
      ex_opcode_op   <= 7'd0;
      ex_rs1_op      <= 5'd0;
      ex_rs2_op      <= 5'd0;
      ex_rd_op       <= 5'd0;
      ex_wb_mux_op   <= NO_WRITEBACK;
      ex_rs1_data_op <= '0;
      ex_rs2_data_op <= '0;
      ex_imm_op      <= '0;
      ex_pc_op       <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_op <= '0;
      flush_count_op <= '0;
    end else begin
      if (stall_op && (stall_count_op != CNT_MAX)) stall_count_op <= stall_count_op + CNT_W'(1);
      if (flush_ip && (flush_count_op != CNT_MAX)) flush_count_op <= flush_count_op + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_buffer.sv
// Bench for id_ex_hazard_buffer: directed hazard scenarios plus random traffic
// against a pipeline-level model; a second instance checks counter saturation.
module tb_id_ex_hazard_buffer;
  import core_pkg::*;

  localparam int XLEN = 32;

  typedef struct packed {
    logic                   valid;
    logic [6:0]             opcode;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    write_back_mux_selector wb;
    logic [XLEN-1:0]        rs1d;
    logic [XLEN-1:0]        rs2d;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        pc;
  } instr_t;

  localparam instr_t BUBBLE = '0;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  instr_t id_in;

  logic                   ex_valid, sm_valid;
  logic [6:0]             ex_opcode, sm_opcode;
  logic [4:0]             ex_rs1, ex_rs2, ex_rd, sm_rs1, sm_rs2, sm_rd;
  write_back_mux_selector ex_wb, sm_wb;
  logic [XLEN-1:0]        ex_rs1d, ex_rs2d, ex_imm, ex_pc;
  logic [XLEN-1:0]        sm_rs1d, sm_rs2d, sm_imm, sm_pc;
  logic                   stall, sm_stall;
  logic [15:0]            stall_cnt, flush_cnt;
  logic [1:0]             sm_stall_cnt, sm_flush_cnt;

  instr_t m_ex;
  int     m_stalls;
  int     m_flushes;
  int     n_pass  = 0;
  int     n_total = 0;

  always #5 clk = ~clk;

  id_ex_hazard_buffer #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid_ip(id_in.valid), .id_opcode_ip(id_in.opcode),
    .id_rs1_ip(id_in.rs1), .id_rs2_ip(id_in.rs2), .id_rd_ip(id_in.rd),
    .id_wb_mux_ip(id_in.wb), .id_rs1_data_ip(id_in.rs1d), .id_rs2_data_ip(id_in.rs2d),
    .id_imm_ip(id_in.imm), .id_pc_ip(id_in.pc), .flush_ip(flush),
    .ex_valid_op(ex_valid), .ex_opcode_op(ex_opcode), .ex_rs1_op(ex_rs1),
    .ex_rs2_op(ex_rs2), .ex_rd_op(ex_rd), .ex_wb_mux_op(ex_wb),
    .ex_rs1_data_op(ex_rs1d), .ex_rs2_data_op(ex_rs2d), .ex_imm_op(ex_imm),
    .ex_pc_op(ex_pc), .stall_op(stall), .stall_count_op(stall_cnt),
    .flush_count_op(flush_cnt)
  );

  id_ex_hazard_buffer #(.XLEN(XLEN), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset),
    .id_valid_ip(id_in.valid), .id_opcode_ip(id_in.opcode),
    .id_rs1_ip(id_in.rs1), .id_rs2_ip(id_in.rs2), .id_rd_ip(id_in.rd),
    .id_wb_mux_ip(id_in.wb), .id_rs1_data_ip(id_in.rs1d), .id_rs2_data_ip(id_in.rs2d),
    .id_imm_ip(id_in.imm), .id_pc_ip(id_in.pc), .flush_ip(flush),
    .ex_valid_op(sm_valid), .ex_opcode_op(sm_opcode), .ex_rs1_op(sm_rs1),
    .ex_rs2_op(sm_rs2), .ex_rd_op(sm_rd), .ex_wb_mux_op(sm_wb),
    .ex_rs1_data_op(sm_rs1d), .ex_rs2_data_op(sm_rs2d), .ex_imm_op(sm_imm),
    .ex_pc_op(sm_pc), .stall_op(sm_stall), .stall_count_op(sm_stall_cnt),
    .flush_count_op(sm_flush_cnt)
  );

  function automatic instr_t dut_ex();
    instr_t r;
    r.valid = ex_valid;  r.opcode = ex_opcode;
    r.rs1 = ex_rs1;      r.rs2 = ex_rs2;      r.rd = ex_rd;
    r.wb = ex_wb;        r.rs1d = ex_rs1d;    r.rs2d = ex_rs2d;
    r.imm = ex_imm;      r.pc = ex_pc;
    return r;
  endfunction

  function automatic instr_t mk(logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, write_back_mux_selector wb);
    instr_t r;
    r.valid = 1'b1; r.opcode = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.wb = wb;
    r.rs1d = $urandom; r.rs2d = $urandom; r.imm = $urandom; r.pc = $urandom & 32'hffff_fffc;
    return r;
  endfunction

  function automatic int sat(int n, int max);
    return (n > max) ? max : n;
  endfunction

  function automatic logic reads_rs1(logic [6:0] op);
    return op inside {OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR};
  endfunction

  function automatic logic reads_rs2(logic [6:0] op);
    return op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
  endfunction

  // A load in EX whose non-zero destination is read by the ID instruction
  // must wait one cycle, unless the ID instruction is being killed anyway.
  function automatic logic model_stall(instr_t ex, instr_t id, logic fl);
    if (fl || !ex.valid || ex.opcode != OPCODE_LOAD || ex.rd == 5'd0 || !id.valid) return 1'b0;
    return (reads_rs1(id.opcode) && id.rs1 == ex.rd) || (reads_rs2(id.opcode) && id.rs2 == ex.rd);
  endfunction

  // One clock: present ins, sample stall mid-cycle, advance the model at the edge.
  task automatic cycle(input instr_t ins, input logic fl, input logic rst,
                       output logic st_dut, output logic st_exp);
    id_in = ins; flush = fl; reset = rst;
    #1;
    st_dut = stall;
    st_exp = model_stall(m_ex, ins, fl);
    @(posedge clk);
    if (rst) begin
      m_ex = BUBBLE; m_stalls = 0; m_flushes = 0;
    end else begin
      if (st_exp) m_stalls++;
      if (fl) m_flushes++;
      m_ex = (fl || st_exp || !ins.valid) ? BUBBLE : ins;
    end
    #1;
  endtask

  task automatic do_reset();
    logic sd, se;
    cycle(BUBBLE, 1'b0, 1'b1, sd, se);
    cycle(BUBBLE, 1'b0, 1'b1, sd, se);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (dut_ex() !== BUBBLE) $display("FAIL reset_ex got=%h exp=%h", dut_ex(), BUBBLE); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
    n_total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); else n_pass++;
    n_total++; if (sm_valid !== 1'b0 || sm_stall_cnt !== 2'd0 || sm_flush_cnt !== 2'd0)
      $display("FAIL reset_small got=%b/%0d/%0d exp=0/0/0", sm_valid, sm_stall_cnt, sm_flush_cnt); else n_pass++;
  endtask

  task automatic test_load_use_rs1();
    instr_t lw, add;
    logic sd, se;
    do_reset();
    lw  = mk(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEMORY_WRITEBACK);
    add = mk(OPCODE_OP, 5'd5, 5'd2, 5'd6, ALU_RESULT_WRITEBACK);
    cycle(lw, 1'b0, 1'b0, sd, se);
    n_total++; if (dut_ex() !== lw) $display("FAIL rs1_lw_in_ex got=%h exp=%h", dut_ex(), lw); else n_pass++;
    cycle(add, 1'b0, 1'b0, sd, se);
    n_total++; if (sd !== 1'b1) $display("FAIL rs1_stall got=%b exp=1", sd); else n_pass++;
    n_total++; if (dut_ex() !== BUBBLE) $display("FAIL rs1_bubble got=%h exp=%h", dut_ex(), BUBBLE); else n_pass++;
    cycle(add, 1'b0, 1'b0, sd, se);
    n_total++; if (sd !== 1'b0) $display("FAIL rs1_stall_len got=%b exp=0", sd); else n_pass++;
    n_total++; if (dut_ex() !== add) $display("FAIL rs1_add_in_ex got=%h exp=%h", dut_ex(), add); else n_pass++;
    n_total++; if (stall_cnt !== 16'd1) $display("FAIL rs1_stall_count got=%0d exp=1", stall_cnt); else n_pass++;
  endtask

  task automatic test_load_use_rs2();
    instr_t lw, sw_a, sw_b;
    logic sd, se;
    do_reset();
    lw   = mk(OPCODE_LOAD, 5'd1, 5'd0, 5'd7, MEMORY_WRITEBACK);
    sw_a = mk(OPCODE_STORE, 5'd3, 5'd7, 5'd4, NO_WRITEBACK);
    sw_b = mk(OPCODE_STORE, 5'd7, 5'd3, 5'd0, NO_WRITEBACK);
    cycle(lw, 1'b0, 1'b0, sd, se);
    cycle(sw_a, 1'b0, 1'b0, sd, se);
    n_total++; if (sd !== 1'b1) $display("FAIL rs2_stall got=%b exp=1", sd); else n_pass++;
    cycle(sw_a, 1'b0, 1'b0, sd, se);
    n_total++; if (sd !== 1'b0 || dut_ex() !== sw_a)
      $display("FAIL rs2_release got=%b/%h exp=0/%h", sd, dut_ex(), sw_a); else n_pass++;
    cycle(lw, 1'b0, 1'b0, sd, se);
    cycle(sw_b, 1'b0, 1'b0, sd, se);
    n_total++; if (sd !== 1'b1) $display("FAIL store_base_stall got=%b exp=1", sd); else n_pass++;
    n_total++; if (stall_cnt !== 16'd2) $display("FAIL rs2_stall_count got=%0d exp=2", stall_cnt); else n_pass++;
  endtask

  task automatic test_x0_no_stall();
    instr_t lw, add;
    logic sd, se;
    do_reset();
    lw  = mk(OPCODE_LOAD, 5'd1, 5'd0, 5'd0, MEMORY_WRITEBACK);
    add = mk(OPCODE_OP, 5'd0, 5'd0, 5'd6, ALU_RESULT_WRITEBACK);
    cycle(lw, 1'b0, 1'b0, sd, se);
    cycle(add, 1'b0, 1'b0, sd, se);
    n_total++; if (sd !== 1'b0) $display("FAIL x0_stall got=%b exp=0", sd); else n_pass++;
    n_total++; if (dut_ex() !== add) $display("FAIL x0_add_in_ex got=%h exp=%h", dut_ex(), add); else n_pass++;
  endtask

  task automatic test_non_load_no_stall();
    instr_t addi, add;
    logic sd, se;
    do_reset();
    addi = mk(OPCODE_OPIMM, 5'd1, 5'd0, 5'd5, ALU_RESULT_WRITEBACK);
    add  = mk(OPCODE_OP, 5'd5, 5'd5, 5'd6, ALU_RESULT_WRITEBACK);
    cycle(addi, 1'b0, 1'b0, sd, se);
    cycle(add, 1'b0, 1'b0, sd, se);
    n_total++; if (sd !== 1'b0) $display("FAIL nonload_stall got=%b exp=0", sd); else n_pass++;
    n_total++; if (ex_rs1 !== 5'd5 || ex_rs2 !== 5'd5 || ex_valid !== 1'b1)
      $display("FAIL nonload_regs got=%0d/%0d/%b exp=5/5/1", ex_rs1, ex_rs2, ex_valid); else n_pass++;
  endtask

  task automatic test_flush_over_stall();
    instr_t lw, add;
    logic sd, se;
    do_reset();
    lw  = mk(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEMORY_WRITEBACK);
    add = mk(OPCODE_OP, 5'd5, 5'd2, 5'd6, ALU_RESULT_WRITEBACK);
    cycle(lw, 1'b0, 1'b0, sd, se);
    cycle(add, 1'b1, 1'b0, sd, se);
    n_total++; if (sd !== 1'b0) $display("FAIL flush_stall got=%b exp=0", sd); else n_pass++;
    n_total++; if (dut_ex() !== BUBBLE) $display("FAIL flush_bubble got=%h exp=%h", dut_ex(), BUBBLE); else n_pass++;
    n_total++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0)
      $display("FAIL flush_counts got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); else n_pass++;
  endtask

  task automatic test_counter_saturation();
    int exp_small[5] = '{1, 2, 3, 3, 3};
    logic sd, se;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(mk(OPCODE_OP, 5'd1, 5'd2, 5'd3, ALU_RESULT_WRITEBACK), 1'b1, 1'b0, sd, se);
      n_total++; if (int'(sm_flush_cnt) !== exp_small[i] || int'(flush_cnt) !== i + 1)
        $display("FAIL flush_sat[%0d] got=%0d/%0d exp=%0d/%0d", i, sm_flush_cnt, flush_cnt, exp_small[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    instr_t lw, add;
    logic sd, se;
    do_reset();
    lw  = mk(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEMORY_WRITEBACK);
    add = mk(OPCODE_OP, 5'd5, 5'd2, 5'd6, ALU_RESULT_WRITEBACK);
    cycle(add, 1'b1, 1'b0, sd, se);
    cycle(lw, 1'b0, 1'b0, sd, se);
    cycle(add, 1'b0, 1'b1, sd, se);
    n_total++; if (sd !== 1'b1) $display("FAIL midrst_stall_before got=%b exp=1", sd); else n_pass++;
    n_total++; if (dut_ex() !== BUBBLE) $display("FAIL midrst_ex got=%h exp=%h", dut_ex(), BUBBLE); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL midrst_stall_after got=%b exp=0", stall); else n_pass++;
    n_total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
      $display("FAIL midrst_counts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] ops[11] = '{OPCODE_LOAD, OPCODE_LOAD, OPCODE_OPIMM, OPCODE_STORE, OPCODE_OP,
                            OPCODE_LUI, OPCODE_BRANCH, OPCODE_JALR, OPCODE_JAL, OPCODE_AUIPC, 7'd0};
    instr_t ins;
    logic sd, se, fl, rst;
    do_reset();
    ins = BUBBLE;
    for (int i = 0; i < 600; i++) begin
      if (!se) begin
        ins = mk(ops[$urandom_range(0, 10)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), write_back_mux_selector'($urandom_range(0, 3)));
        if ($urandom_range(0, 19) == 0) ins.opcode = 7'($urandom);
        ins.valid = ($urandom_range(0, 9) != 0);
      end
      fl  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle(ins, fl, rst, sd, se);
      n_total++; if (sd !== se) $display("FAIL rand_stall[%0d] got=%b exp=%b", i, sd, se); else n_pass++;
      n_total++; if (dut_ex() !== m_ex) $display("FAIL rand_ex[%0d] got=%h exp=%h", i, dut_ex(), m_ex); else n_pass++;
      n_total++; if (int'(stall_cnt) !== sat(m_stalls, 65535) || int'(flush_cnt) !== sat(m_flushes, 65535))
        $display("FAIL rand_counts[%0d] got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt,
                 sat(m_stalls, 65535), sat(m_flushes, 65535));
      else n_pass++;
      n_total++; if (int'(sm_stall_cnt) !== sat(m_stalls, 3) || int'(sm_flush_cnt) !== sat(m_flushes, 3)
                     || sm_valid !== m_ex.valid)
        $display("FAIL rand_small[%0d] got=%0d/%0d/%b exp=%0d/%0d/%b", i, sm_stall_cnt, sm_flush_cnt,
                 sm_valid, sat(m_stalls, 3), sat(m_flushes, 3), m_ex.valid);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; id_in = BUBBLE;
    m_ex = BUBBLE; m_stalls = 0; m_flushes = 0;
    test_reset();
    test_load_use_rs1();
    test_load_use_rs2();
    test_x0_no_stall();
    test_non_load_no_stall();
    test_flush_over_stall();
    test_counter_saturation();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
